// File: rtl/dmem_load_unit.sv
// Data-memory load unit: accepts a load, reads one aligned DMEM word and returns the extracted/extended result.
// Optional feature: define DMEM_LD_TIMEOUT_EN to fault a load after 15 WAIT cycles without read data.
module dmem_load_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [5:0]  instr_opcode_i,
    input  logic [31:0] alu_out_i,
    output logic        mem_re_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        rd_valid_o,
    output logic [31:0] rd_data_o,
    output logic        ld_fault_o
);

    localparam int unsigned OP_W   = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WADR_W = 30;

    localparam logic [OP_W-1:0] OP_LB  = 6'b100000;
    localparam logic [OP_W-1:0] OP_LH  = 6'b100001;
    localparam logic [OP_W-1:0] OP_LW  = 6'b100010;
    localparam logic [OP_W-1:0] OP_LBU = 6'b100100;
    localparam logic [OP_W-1:0] OP_LHU = 6'b100101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [OP_W-1:0]     op_q;
    logic [1:0]          off_q;
    logic [WADR_W-1:0]   waddr_q;
    logic [DATA_W-1:0]   data_q;
    logic                fault_q;

    logic                is_load_c;
    logic                misalign_c;
    logic                accept_c;
    logic                capture_c;
    logic                timeout_c;

`ifdef DMEM_LD_TIMEOUT_EN
    localparam int unsigned CNT_W = 4;
    logic [CNT_W-1:0]    cnt_q;
`endif

    // Lane extraction and extension, driven only by the registered opcode/offset.
    function automatic logic [DATA_W-1:0] extract(input logic [OP_W-1:0] op,
                                                  input logic [1:0] off,
                                                  input logic [DATA_W-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (op)
            OP_LB:   extract = {{24{b[7]}}, b};
            OP_LBU:  extract = {24'd0, b};
            OP_LH:   extract = {{16{h[15]}}, h};
            OP_LHU:  extract = {16'd0, h};
            OP_LW:   extract = {w[31:16], w[7:0], w[15:8]};
            default: extract = '0;
        endcase
    endfunction

    assign is_load_c = (instr_opcode_i == OP_LB)  || (instr_opcode_i == OP_LH)  ||
                       (instr_opcode_i == OP_LW)  || (instr_opcode_i == OP_LBU) ||
                       (instr_opcode_i == OP_LHU);

    assign misalign_c = (((instr_opcode_i == OP_LH) || (instr_opcode_i == OP_LHU)) && alu_out_i[0]) ||
                        ((instr_opcode_i == OP_LW) && (alu_out_i[1:0] != 2'b00));

    // Next-state and per-cycle strobes.
    always_comb begin
        state_d   = state_q;
        accept_c  = 1'b0;
        capture_c = 1'b0;
        timeout_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i && is_load_c) begin
                    accept_c = 1'b1;
                    state_d  = misalign_c ? RESP : REQ;
                end
            end
            REQ:  state_d = WAIT;
            WAIT: begin
                if (mem_rvalid_i) begin
                    capture_c = 1'b1;
                    state_d   = RESP;
                end
`ifdef DMEM_LD_TIMEOUT_EN
                else if (cnt_q == 4'd14) begin
                    timeout_c = 1'b1;
                    state_d   = RESP;
                end
`endif
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= '0;
            off_q   <= '0;
            waddr_q <= '0;
            data_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept_c) begin
                op_q    <= instr_opcode_i;
                off_q   <= alu_out_i[1:0];
                waddr_q <= alu_out_i[31:2];
                data_q  <= '0;
                fault_q <= misalign_c;
            end
            if (capture_c) begin
                data_q <= extract(op_q, off_q, mem_rdata_i);
            end
            if (timeout_c) begin
                fault_q <= 1'b1;
            end
        end
    end

`ifdef DMEM_LD_TIMEOUT_EN
    // Counts WAIT cycles without read data; restarts each time REQ hands over to WAIT.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state_q == REQ) begin
            cnt_q <= '0;
        end else if ((state_q == WAIT) && !mem_rvalid_i) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end
`endif

    assign req_ready_o = (state_q == IDLE);
    assign mem_re_o    = (state_q == REQ);
    assign mem_addr_o  = ((state_q == REQ) || (state_q == WAIT)) ? {waddr_q, 2'b00} : 32'd0;
    assign rd_valid_o  = (state_q == RESP);
    assign rd_data_o   = data_q;
    assign ld_fault_o  = fault_q;

endmodule

// File: tb/tb_dmem_load_unit.sv
// Directed self-checking bench for dmem_load_unit: vector table plus reset, ignore and timeout sequences.
module tb_dmem_load_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [5:0]  instr_opcode_i;
    logic [31:0] alu_out_i;
    logic        mem_re_o;
    logic [31:0] mem_addr_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        rd_valid_o;
    logic [31:0] rd_data_o;
    logic        ld_fault_o;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LW  = 6'b100010;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] LHU = 6'b100101;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] exp_data;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[12];

    dmem_load_unit dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .instr_opcode_i (instr_opcode_i),
        .alu_out_i      (alu_out_i),
        .mem_re_o       (mem_re_o),
        .mem_addr_o     (mem_addr_o),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .rd_valid_o     (rd_valid_o),
        .rd_data_o      (rd_data_o),
        .ld_fault_o     (ld_fault_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present a request for one cycle; returns after the accept edge, inputs scrambled.
    task automatic issue(input logic [5:0] op, input logic [31:0] addr);
        check("ready_before_req", 32'(req_ready_o), 32'd1);
        req_valid_i    = 1'b1;
        instr_opcode_i = op;
        alu_out_i      = addr;
        step();
        req_valid_i    = 1'b0;
        instr_opcode_i = LW;
        alu_out_i      = 32'hFFFF_FFFF;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        issue(v.op, v.addr);
        if (v.exp_fault) begin
            check({tag, "_re_fault"},    32'(mem_re_o),   32'd0);
            check({tag, "_valid_fault"}, 32'(rd_valid_o), 32'd1);
            check({tag, "_fault"},       32'(ld_fault_o), 32'd1);
            check({tag, "_data_fault"},  rd_data_o,       32'd0);
        end else begin
            check({tag, "_re"},   32'(mem_re_o), 32'd1);
            check({tag, "_addr"}, mem_addr_o,    {v.addr[31:2], 2'b00});
            check({tag, "_ready_busy"}, 32'(req_ready_o), 32'd0);
            step();
            check({tag, "_re_once"},   32'(mem_re_o), 32'd0);
            check({tag, "_addr_wait"}, mem_addr_o,    {v.addr[31:2], 2'b00});
            check({tag, "_no_valid"},  32'(rd_valid_o), 32'd0);
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = v.rdata;
            step();
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 32'h5A5A_5A5A;
            check({tag, "_valid"}, 32'(rd_valid_o), 32'd1);
            check({tag, "_data"},  rd_data_o,       v.exp_data);
            check({tag, "_fault"}, 32'(ld_fault_o), 32'd0);
            check({tag, "_addr_resp"}, mem_addr_o,  32'd0);
        end
        step();
        check({tag, "_valid_pulse"}, 32'(rd_valid_o),  32'd0);
        check({tag, "_ready_after"}, 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        int cyc;
        int wait_cycles;
        logic got_valid;

        vecs[0]  = '{LB,  32'h0000_0103, 32'h80FF_1234, 32'hFFFF_FF80, 1'b0};
        vecs[1]  = '{LHU, 32'h0000_0202, 32'h9ABC_0000, 32'h0000_9ABC, 1'b0};
        vecs[2]  = '{LH,  32'h0000_0202, 32'h9ABC_0000, 32'hFFFF_9ABC, 1'b0};
        vecs[3]  = '{LW,  32'h0000_0300, 32'h1122_3344, 32'h1122_4433, 1'b0};
        vecs[4]  = '{LW,  32'h0000_0301, 32'h0,         32'h0,         1'b1};
        vecs[5]  = '{LBU, 32'h0000_0101, 32'h80FF_1234, 32'h0000_0012, 1'b0};
        vecs[6]  = '{LB,  32'h0000_0100, 32'h80FF_1234, 32'h0000_0034, 1'b0};
        vecs[7]  = '{LBU, 32'h0000_0103, 32'h80FF_1234, 32'h0000_0080, 1'b0};
        vecs[8]  = '{LH,  32'h0000_0200, 32'h1234_8765, 32'hFFFF_8765, 1'b0};
        vecs[9]  = '{LH,  32'h0000_0203, 32'h0,         32'h0,         1'b1};
        vecs[10] = '{LHU, 32'h0000_0201, 32'h0,         32'h0,         1'b1};
        vecs[11] = '{LW,  32'h0000_0302, 32'h0,         32'h0,         1'b1};

        rst_i          = 1'b1;
        req_valid_i    = 1'b0;
        instr_opcode_i = 6'd0;
        alu_out_i      = 32'd0;
        mem_rvalid_i   = 1'b0;
        mem_rdata_i    = 32'd0;
        step();
        step();
        check("rst_ready", 32'(req_ready_o), 32'd1);
        check("rst_re",    32'(mem_re_o),    32'd0);
        check("rst_addr",  mem_addr_o,       32'd0);
        check("rst_valid", 32'(rd_valid_o),  32'd0);
        check("rst_data",  rd_data_o,        32'd0);
        check("rst_fault", 32'(ld_fault_o),  32'd0);
        rst_i = 1'b0;
        step();

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], i);
        end

        // Non-load opcode with req_valid_i is ignored.
        req_valid_i    = 1'b1;
        instr_opcode_i = 6'b101000;
        alu_out_i      = 32'h0000_0400;
        step();
        req_valid_i = 1'b0;
        check("nonload_ready", 32'(req_ready_o), 32'd1);
        check("nonload_re",    32'(mem_re_o),    32'd0);
        check("nonload_valid", 32'(rd_valid_o),  32'd0);
        step();
        check("nonload_valid2", 32'(rd_valid_o), 32'd0);
        check("nonload_re2",    32'(mem_re_o),   32'd0);

        // Reset in WAIT abandons the load; late read data is ignored.
        issue(LW, 32'h0000_0300);
        step();
        check("rstw_in_wait", mem_addr_o, 32'h0000_0300);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("rstw_ready", 32'(req_ready_o), 32'd1);
        check("rstw_addr",  mem_addr_o,       32'd0);
        check("rstw_data",  rd_data_o,        32'd0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_BEEF;
        step();
        mem_rvalid_i = 1'b0;
        check("rstw_late_valid", 32'(rd_valid_o),  32'd0);
        check("rstw_late_ready", 32'(req_ready_o), 32'd1);
        step();
        check("rstw_late_valid2", 32'(rd_valid_o), 32'd0);
        check("rstw_late_data",   rd_data_o,       32'd0);

        // Read data that never arrives.
        issue(LB, 32'h0000_0500);
        check("to_re", 32'(mem_re_o), 32'd1);
        got_valid   = 1'b0;
        wait_cycles = 0;
`ifdef DMEM_LD_TIMEOUT_EN
        for (cyc = 1; cyc <= 40; cyc++) begin
            step();
            if (rd_valid_o) begin
                got_valid   = 1'b1;
                wait_cycles = cyc - 1;
                break;
            end
        end
        check("to_seen",   32'(got_valid),   32'd1);
        check("to_cycles", 32'(wait_cycles), 32'd15);
        check("to_fault",  32'(ld_fault_o),  32'd1);
        check("to_data",   rd_data_o,        32'd0);
        step();
        check("to_ready",  32'(req_ready_o), 32'd1);
`else
        for (cyc = 1; cyc <= 30; cyc++) begin
            step();
            if (rd_valid_o) got_valid = 1'b1;
        end
        check("hold_no_valid", 32'(got_valid),  32'd0);
        check("hold_addr",     mem_addr_o,      32'h0000_0500);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000_00F0;
        step();
        mem_rvalid_i = 1'b0;
        check("hold_valid", 32'(rd_valid_o), 32'd1);
        check("hold_data",  rd_data_o,       32'hFFFF_FFF0);
        check("hold_fault", 32'(ld_fault_o), 32'd0);
        step();
        check("hold_ready", 32'(req_ready_o), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_load_unit.md
DMEM_LOAD_UNIT -- requirements
Module: dmem_load_unit

Interface
REQ-001 The module SHALL have the port clk_i, input, 1 bit: system clock; all state changes on its rising edge.
REQ-002 The module SHALL have the port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-003 The module SHALL have the port req_valid_i, input, 1 bit: load request present.
REQ-004 The module SHALL have the port req_ready_o, output, 1 bit: unit can accept a request.
REQ-005 The module SHALL have the port instr_opcode_i, input, 6 bits: load opcode, where LB=100000, LH=100001, LW=100010, LBU=100100, LHU=100101.
REQ-006 The module SHALL have the port alu_out_i, input, 32 bits: effective byte address.
REQ-007 The module SHALL have the port mem_re_o, output, 1 bit: DMEM read strobe.
REQ-008 The module SHALL have the port mem_addr_o, output, 32 bits: word-aligned DMEM address, equal to {addr[31:2],2'b00}.
REQ-009 The module SHALL have the port mem_rvalid_i, input, 1 bit: DMEM read data valid.
REQ-010 The module SHALL have the port mem_rdata_i, input, 32 bits: raw DMEM word.
REQ-011 The module SHALL have the port rd_valid_o, output, 1 bit: load result valid, pulsed for 1 cycle.
REQ-012 The module SHALL have the port rd_data_o, output, 32 bits: extracted and extended load result.
REQ-013 The module SHALL have the port ld_fault_o, output, 1 bit: misaligned or failed load, qualified by rd_valid_o.

Function
REQ-014 The FSM SHALL have the states IDLE, REQ, WAIT and RESP, and req_ready_o SHALL be 1 only in IDLE.
REQ-015 In IDLE, when req_valid_i=1 and the opcode is one of the five loads, the unit SHALL accept the request and register the opcode, alu_out_i and the byte offset alu_out_i[1:0].
REQ-016 In IDLE, a request with a non-load opcode SHALL be ignored: no state change and no response.
REQ-017 An accepted LH or LHU with offset[0]=1, or an LW with offset!=00, SHALL go IDLE->RESP without a memory read, with ld_fault_o=1 and rd_data_o=0.
REQ-018 An accepted aligned load SHALL go IDLE->REQ; in REQ, mem_re_o=1 for exactly 1 cycle, and then the FSM SHALL go to WAIT.
REQ-019 In WAIT, mem_rvalid_i=1 SHALL capture mem_rdata_i and move to RESP; mem_rvalid_i SHALL be ignored in every other state.
REQ-020 In RESP, rd_valid_o=1 for exactly 1 cycle, and then the FSM SHALL return to IDLE; there is no output backpressure.
REQ-021 The minimum latency SHALL be: accept at cycle T, mem_re_o at T+1, mem_rvalid_i at T+2 at the earliest, and rd_valid_o at T+3.
REQ-022 Byte selection for LB and LBU SHALL be lane offset, i.e. bits [8*off+7:8*off]; LB SHALL sign-extend from bit 7 and LBU SHALL zero-extend.
REQ-023 Halfword selection for LH and LHU SHALL be rdata[15:0] for offset 00 and rdata[31:16] for offset 10; LH SHALL sign-extend from bit 15 and LHU SHALL zero-extend.
REQ-024 LW SHALL return {rdata[31:16], rdata[7:0], rdata[15:8]}, exchanging lanes 0 and 1 to match the store-side word lane order.
REQ-025 mem_addr_o SHALL hold the registered aligned address from REQ through WAIT, and SHALL be 0 otherwise.
REQ-026 The extraction SHALL be computed from the registered opcode and offset, so that input changes after acceptance have no effect.

Reset
REQ-027 When rst_i=1, the state SHALL go to IDLE and all registers SHALL clear; req_ready_o=1, mem_re_o=0, mem_addr_o=0, rd_valid_o=0, rd_data_o=0 and ld_fault_o=0.
REQ-028 A reset asserted mid-operation SHALL abandon the outstanding load, and a later mem_rvalid_i arriving in IDLE SHALL be ignored.

Configuration
REQ-029 With the macro DMEM_LD_TIMEOUT_EN defined, a 4-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle without mem_rvalid_i, and when it reaches 15 the FSM SHALL go to RESP with ld_fault_o=1 and rd_data_o=0.
REQ-030 Without DMEM_LD_TIMEOUT_EN, WAIT SHALL be held indefinitely until mem_rvalid_i, and no counter logic SHALL be present.

Verification
REQ-031 The bench SHALL cover: LB addr=0x103, rdata=0x80FF1234, rvalid one cycle after mem_re_o -> mem_addr_o=0x100, rd_data_o=0xFFFFFF80, ld_fault_o=0, rd_valid_o 3 cycles after accept.
REQ-032 The bench SHALL cover: LHU addr=0x202 and LH addr=0x202, with rdata=0x9ABC0000 -> 0x00009ABC and 0xFFFF9ABC respectively.
REQ-033 The bench SHALL cover: LW addr=0x300, rdata=0x11223344 -> rd_data_o=0x11224433.
REQ-034 The bench SHALL cover: LW addr=0x301 -> no mem_re_o, rd_valid_o=1 with ld_fault_o=1 and rd_data_o=0 one cycle after accept; and opcode 101000 with req_valid_i=1 -> no response.
REQ-035 The bench SHALL cover: rst_i=1 in WAIT, followed by mem_rvalid_i=1 -> no rd_valid_o, and req_ready_o=1 in the cycle after reset.
REQ-036 The bench SHALL cover, with DMEM_LD_TIMEOUT_EN defined: no mem_rvalid_i after mem_re_o -> rd_valid_o=1 with ld_fault_o=1 after 15 WAIT cycles.
